// File: rtl/pad_bank_arbiter.sv
// Two-requester arbiter for a bank of OEN/I/O/PEN pad cells, with a tristate turnaround on every handover.
// Define PAD_BANK_INSYNC_EN to pass pad input data through a two-flop synchronizer instead of one register.
module pad_bank_arbiter #(
  parameter int NPADS       = 4,
  parameter int TURN_CYCLES = 2,
  parameter int TURN_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_i,
  output logic [1:0]       gnt_o,
  input  logic [NPADS-1:0] r0_oen_i,
  input  logic [NPADS-1:0] r0_out_i,
  input  logic [NPADS-1:0] r0_pen_i,
  input  logic [NPADS-1:0] r1_oen_i,
  input  logic [NPADS-1:0] r1_out_i,
  input  logic [NPADS-1:0] r1_pen_i,
  input  logic [NPADS-1:0] pad_in_i,
  output logic [NPADS-1:0] rd_data_o,
  output logic [NPADS-1:0] pad_oen_o,
  output logic [NPADS-1:0] pad_out_o,
  output logic [NPADS-1:0] pad_pen_o,
  output logic             busy_o
);

  // IDLE: bank free | OWN0/OWN1: requester k drives the pads | TURN: all pads tristated between owners
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_e;

  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYCLES - 1);

  state_e            state_q;
  logic [1:0]        gnt_q;
  logic              last_q;
  logic [TURN_W-1:0] cnt_q;
  logic [NPADS-1:0]  oen_q;
  logic [NPADS-1:0]  out_q;
  logic [NPADS-1:0]  pen_q;
  logic [NPADS-1:0]  rd_q;
  state_e            arb_d;

  // Round-robin pick: on a tie the requester that was not served last wins.
  function automatic state_e pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return last ? OWN0 : OWN1;
    else if (req[0])  return OWN0;
    else if (req[1])  return OWN1;
    else              return IDLE;
  endfunction

  function automatic logic [1:0] gnt_of(input state_e s);
    case (s)
      OWN0:    return 2'b01;
      OWN1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    arb_d = pick(req_i, last_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      oen_q   <= '1;
      out_q   <= '0;
      pen_q   <= '1;
    end else begin
      // Pads fall back to safe (undriven, pulled) unless an owner keeps them this cycle.
      oen_q <= '1;
      out_q <= '0;
      pen_q <= '1;
      case (state_q)
        IDLE: begin
          state_q <= arb_d;
          gnt_q   <= gnt_of(arb_d);
        end
        OWN0: begin
          if (req_i[0]) begin
            oen_q <= r0_oen_i;
            out_q <= r0_out_i;
            pen_q <= r0_pen_i;
          end else begin
            state_q <= TURN;
            gnt_q   <= 2'b00;
            last_q  <= 1'b0;
            cnt_q   <= TURN_LOAD;
          end
        end
        OWN1: begin
          if (req_i[1]) begin
            oen_q <= r1_oen_i;
            out_q <= r1_out_i;
            pen_q <= r1_pen_i;
          end else begin
            state_q <= TURN;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= TURN_LOAD;
          end
        end
        TURN: begin
          if (cnt_q == '0) begin
            state_q <= arb_d;
            gnt_q   <= gnt_of(arb_d);
          end else begin
            cnt_q <= cnt_q - TURN_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

`ifdef PAD_BANK_INSYNC_EN
  logic [NPADS-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      rd_q   <= '0;
    end else begin
      sync_q <= pad_in_i;
      rd_q   <= sync_q;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_q <= '0;
    else       rd_q <= pad_in_i;
  end
`endif

  assign gnt_o     = gnt_q;
  assign pad_oen_o = oen_q;
  assign pad_out_o = out_q;
  assign pad_pen_o = pen_q;
  assign rd_data_o = rd_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_pad_bank_arbiter.sv
// Scoreboard bench for pad_bank_arbiter: each driven cycle pushes its expected outputs, the negedge checker pops them.
module tb_pad_bank_arbiter;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic [NP-1:0] r0_oen, r0_out, r0_pen, r1_oen, r1_out, r1_pen;
  logic [NP-1:0] pad_in, rd_data, pad_oen, pad_out, pad_pen;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]    gnt;
    logic [NP-1:0] oen;
    logic [NP-1:0] out;
    logic [NP-1:0] pen;
    logic [NP-1:0] rd;
    logic          busy;
    string         tag;
  } exp_t;

  exp_t          sb_q[$];
  logic [NP-1:0] pin_prev = '0;

  pad_bank_arbiter #(.NPADS(NP), .TURN_CYCLES(2), .TURN_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt),
    .r0_oen_i(r0_oen), .r0_out_i(r0_out), .r0_pen_i(r0_pen),
    .r1_oen_i(r1_oen), .r1_out_i(r1_out), .r1_pen_i(r1_pen),
    .pad_in_i(pad_in), .rd_data_o(rd_data),
    .pad_oen_o(pad_oen), .pad_out_o(pad_out), .pad_pen_o(pad_pen),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.tag, " gnt"},  32'(gnt),     32'(e.gnt));
      check({e.tag, " oen"},  32'(pad_oen), 32'(e.oen));
      check({e.tag, " out"},  32'(pad_out), 32'(e.out));
      check({e.tag, " pen"},  32'(pad_pen), 32'(e.pen));
      check({e.tag, " busy"}, 32'(busy),    32'(e.busy));
      check({e.tag, " rd"},   32'(rd_data), 32'(e.rd));
      check({e.tag, " gnt_not_11"}, 32'(gnt == 2'b11), 32'(0));
      check({e.tag, " oen_only_when_owned"}, 32'((pad_oen != '1) && (gnt == 2'b00)), 32'(0));
    end
  end

  // Drive one cycle of inputs and push the outputs expected after the next rising edge.
  task automatic cyc(input string tag, input logic r, input logic [1:0] rq, input logic [NP-1:0] pin,
                     input logic [1:0] egnt, input logic [NP-1:0] eoen, input logic [NP-1:0] eout,
                     input logic [NP-1:0] epen, input logic ebusy);
    exp_t e;
    rst    = r;
    req    = rq;
    pad_in = pin;
    e.tag  = tag;
    e.gnt  = egnt;
    e.oen  = eoen;
    e.out  = eout;
    e.pen  = epen;
    e.busy = ebusy;
`ifdef PAD_BANK_INSYNC_EN
    e.rd     = r ? '0 : pin_prev;
    pin_prev = r ? '0 : pin;
`else
    e.rd     = r ? '0 : pin;
`endif
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fixed_vals();
    r0_oen = 4'h0; r0_out = 4'hA; r0_pen = 4'h3;
    r1_oen = 4'h3; r1_out = 4'h5; r1_pen = 4'hC;
  endtask

  task automatic random_vals();
    r0_oen = 4'($urandom); r0_out = 4'($urandom); r0_pen = 4'($urandom);
    r1_oen = 4'($urandom); r1_out = 4'($urandom); r1_pen = 4'($urandom);
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; pad_in = '0;
    random_vals();
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      random_vals();
      cyc("reset", 1'b1, 2'($urandom), 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b0);
    end
    fixed_vals();
    // Single owner and handover 0 -> 1
    cyc("grant0",    1'b0, 2'b01, 4'($urandom), 2'b01, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("own0_pads", 1'b0, 2'b01, 4'($urandom), 2'b01, 4'h0, 4'hA, 4'h3, 1'b1);
    random_vals();
    r0_oen = 4'h0; r0_out = 4'hA; r0_pen = 4'h3;
    cyc("r1_ignored", 1'b0, 2'b01, 4'($urandom), 2'b01, 4'h0, 4'hA, 4'h3, 1'b1);
    fixed_vals();
    cyc("no_preempt", 1'b0, 2'b11, 4'($urandom), 2'b01, 4'h0, 4'hA, 4'h3, 1'b1);
    cyc("turn1",      1'b0, 2'b10, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("turn2",      1'b0, 2'b10, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("grant1",     1'b0, 2'b10, 4'($urandom), 2'b10, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("own1_pads",  1'b0, 2'b10, 4'($urandom), 2'b10, 4'h3, 4'h5, 4'hC, 1'b1);
    cyc("rel_turn1",  1'b0, 2'b00, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("rel_turn2",  1'b0, 2'b00, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("idle",       1'b0, 2'b00, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b0);
    cyc("idle_hold",  1'b0, 2'b00, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b0);
    // Simultaneous requests from reset, then round-robin with re-raised req0
    cyc("reset2",     1'b1, 2'b11, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b0);
    cyc("tie_r0",     1'b0, 2'b11, 4'($urandom), 2'b01, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("tie_r0_pad", 1'b0, 2'b11, 4'($urandom), 2'b01, 4'h0, 4'hA, 4'h3, 1'b1);
    cyc("r0_drop",    1'b0, 2'b10, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("r0_reraise", 1'b0, 2'b11, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("rr_r1",      1'b0, 2'b11, 4'($urandom), 2'b10, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("rr_r1_pad",  1'b0, 2'b11, 4'($urandom), 2'b10, 4'h3, 4'h5, 4'hC, 1'b1);
    // Back to requester 0, then reset in the second turnaround cycle
    cyc("r1_drop",    1'b0, 2'b01, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("r1_turn2",   1'b0, 2'b01, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("regrant0",   1'b0, 2'b01, 4'($urandom), 2'b01, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("regrant0_p", 1'b0, 2'b01, 4'($urandom), 2'b01, 4'h0, 4'hA, 4'h3, 1'b1);
    cyc("r0_rel",     1'b0, 2'b00, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("r0_rel_t2",  1'b0, 2'b00, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("rst_mid",    1'b1, 2'b11, 4'($urandom), 2'b00, 4'hF, 4'h0, 4'hF, 1'b0);
    cyc("post_rst_tie", 1'b0, 2'b11, 4'($urandom), 2'b01, 4'hF, 4'h0, 4'hF, 1'b1);
    cyc("post_rst_pad", 1'b0, 2'b11, 4'($urandom), 2'b01, 4'h0, 4'hA, 4'h3, 1'b1);
    // Input path toggles
    cyc("pin5",       1'b0, 2'b01, 4'h5, 2'b01, 4'h0, 4'hA, 4'h3, 1'b1);
    cyc("pinA",       1'b0, 2'b01, 4'hA, 2'b01, 4'h0, 4'hA, 4'h3, 1'b1);
    cyc("pin5b",      1'b0, 2'b01, 4'h5, 2'b01, 4'h0, 4'hA, 4'h3, 1'b1);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pad_bank_arbiter.md
Name: pad_bank_arbiter

Overview:
- Shares one bank of NPADS bidirectional pad cells (OEN/I/O/PEN pad wrappers) between two requesters, e.g. GPIO (requester 0) and a peripheral such as SPI or QSPI (requester 1).
- Arbitrates ownership with a req/gnt handshake.
- Inserts a programmable tristate turnaround window on every ownership change, so two drivers never contend on the pad.
- Routes pad input data back to both requesters.
- Sits between the peripherals and the pad-wrapper instances in the pad frame.

Parameters:
- NPADS, 4, number of pads in the bank (1..32).
- TURN_CYCLES, 2, dead cycles with all pads tristated between owners (1..15).
- TURN_W, 4, width of the turnaround counter; must hold TURN_CYCLES.

Ports:
- clk_i  in  1  bank clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  2  ownership request, one bit per requester.
- gnt_o  out  2  ownership grant, one-hot or zero.
- r0_oen_i  in  NPADS  requester 0 output-enable-n per pad (1 = input).
- r0_out_i  in  NPADS  requester 0 drive data.
- r0_pen_i  in  NPADS  requester 0 pull enable.
- r1_oen_i, r1_out_i, r1_pen_i  in  NPADS each  same signals for requester 1.
- pad_in_i  in  NPADS  O from the pad cells.
- rd_data_o  out  NPADS  pad input data, broadcast to both requesters.
- pad_oen_o  out  NPADS  OEN to the pad cells.
- pad_out_o  out  NPADS  I to the pad cells.
- pad_pen_o  out  NPADS  PEN to the pad cells.
- busy_o  out  1  high while owned or in turnaround.

Behaviour:
- Single clock domain; all state is in registers updated on the rising edge of clk_i.
- While rst_i is high: all registers reset, state=IDLE, gnt_o=0, pad_oen_o=all 1, pad_out_o=0, pad_pen_o=all 1 (safe pulled, undriven), busy_o=0, rd_data_o=0, last-served pointer=1 (so requester 0 wins the first tie).
- FSM states: IDLE, OWN0, OWN1, TURN.
- IDLE:
  - If exactly one req_i bit is set, go to OWNk.
  - If both are set, grant the requester that is not the last-served one (round-robin).
  - gnt_o asserts in the cycle after req_i is sampled: one-cycle grant latency.
- OWNk:
  - gnt_o[k]=1.
  - pad_* outputs are registered copies of rk_* inputs: one-cycle latency from rk_* to the pads.
  - Stay while req_i[k]=1; the other requester's req is ignored (no preemption).
  - On req_i[k]=0, go to TURN, record last-served=k, and deassert gnt_o the same edge.
- TURN:
  - gnt_o=0, pad_oen_o=all 1, pad_out_o=0, pad_pen_o=all 1.
  - Counter loads TURN_CYCLES-1 on entry and decrements each cycle.
  - Stay for exactly TURN_CYCLES cycles, then evaluate requests as in IDLE: go to OWNk directly if a request is pending, else go to IDLE.
- IDLE outputs: same as TURN (tristate, pulled).
- busy_o = (state != IDLE).
- rd_data_o = pad_in_i registered once (one-cycle latency), in every state.
- Requester outputs without a grant are ignored completely.
- A requester dropping and re-raising req in back-to-back cycles still incurs the full turnaround and loses a tie to the other requester.
- Both requests arriving in the same cycle as TURN expiry are resolved by round-robin; the just-released owner loses.
- Reset asserted mid-ownership or mid-TURN: next edge returns to the reset values; no partial turnaround completes.
- Invariant: gnt_o is never 2'b11, and pad_oen_o has a 0 bit only in OWN0 or OWN1.

Optional Feature:
- Macro: PAD_BANK_INSYNC_EN.
- When defined: rd_data_o passes through a two-flop synchronizer instead of one register. Latency from pad_in_i is 2 cycles; reset value stays 0. Used when pads carry asynchronous external inputs.
- When undefined: single register, 1-cycle latency, as in Behaviour.

Test Plan:
- Reset: assert rst_i for 3 cycles with random inputs -> gnt_o=0, pad_oen_o all 1, pad_pen_o all 1, pad_out_o=0, busy_o=0.
- Single owner: req_i=01, r0_oen_i=0, r0_out_i=4'hA -> gnt_o=01 one cycle later; pad_oen_o=0 and pad_out_o=4'hA the following cycle; r1_* changes have no effect.
- Handover, TURN_CYCLES=2: r0 holds, r1 requests, then r0 drops req -> exactly 2 cycles of gnt_o=0 with pad_oen_o=4'hF, then gnt_o=10 with r1 values on the pads; gnt_o never 11.
- Simultaneous requests from reset: req_i=11 -> requester 0 granted; after its release, requester 1 granted even though req_i[0] is re-raised.
- Input path: toggle pad_in_i=4'h5 then 4'hA -> rd_data_o follows after 1 cycle (2 cycles with PAD_BANK_INSYNC_EN defined).
- Reset mid-TURN: assert rst_i during the second turnaround cycle -> next cycle in IDLE, reset values on all outputs, and requester 0 wins the next tie.
